// File: rtl/fpcvt_sched.sv
// fpcvt_sched: two-requester round-robin front end for a single FPCVT
// converter (13-bit two's complement -> sign / 3-bit exponent / 5-bit
// fraction), with a registered, back-pressured result port and a
// saturation-event counter.

// FPCVT: purely combinational converter. The fraction keeps the five bits
// below and including the leading one. It rounds on the next lower bit.
// A rounding carry bumps the exponent. Magnitudes that cannot be
// represented clamp to E=7, F=31.
module fpcvt (
    input  logic [12:0] d_i,
    output logic        s_o,
    output logic [2:0]  e_o,
    output logic [4:0]  f_o
);
    logic [12:0] mag;
    logic [3:0]  lead;
    logic [2:0]  e_raw;
    logic [5:0]  win;
    logic [5:0]  rnd;

    // normalise, round, and clamp
    always_comb begin
        s_o   = d_i[12];
        mag   = d_i[12] ? (~d_i + 13'd1) : d_i;
        lead  = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (mag[i]) lead = 4'(i);
        end
        e_raw = 3'd0;
        win   = 6'd0;
        rnd   = 6'd0;
        e_o   = 3'd0;
        f_o   = 5'd0;
        if (mag[12]) begin
            // only -4096 reaches bit 12
            e_o = 3'd7;
            f_o = 5'd31;
        end else if (lead < 4'd5) begin
            // fits in the fraction exactly, nothing to round
            e_o = 3'd0;
            f_o = mag[4:0];
        end else begin
            e_raw = 3'(lead - 4'd4);
            win   = 6'(mag >> (lead - 4'd5));
            rnd   = {1'b0, win[5:1]} + {5'd0, win[0]};
            if (rnd[5]) begin
                if (e_raw == 3'd7) begin
                    e_o = 3'd7;
                    f_o = 5'd31;
                end else begin
                    e_o = e_raw + 3'd1;
                    f_o = 5'b10000;
                end
            end else begin
                e_o = e_raw;
                f_o = rnd[4:0];
            end
        end
    end
endmodule

module fpcvt_sched #(
    parameter int SAT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [12:0]          req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [12:0]          req1_data,
    output logic                 req1_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_s,
    output logic [2:0]           out_e,
    output logic [4:0]           out_f,
    output logic                 out_id,
    output logic [SAT_CNT_W-1:0] sat_count,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [12:0]           opnd_q, opnd_d;
    logic                  id_q, id_d;
    logic                  ov_q, ov_d;
    logic                  os_q, os_d;
    logic [2:0]            oe_q, oe_d;
    logic [4:0]            of_q, of_d;
    logic                  oid_q, oid_d;
    logic [SAT_CNT_W-1:0]  sat_q, sat_d;

    logic                  cv_s;
    logic [2:0]            cv_e;
    logic [4:0]            cv_f;
    logic                  gnt_id;
    logic                  gnt_any;

    fpcvt u_cvt (
        .d_i (opnd_q),
        .s_o (cv_s),
        .e_o (cv_e),
        .f_o (cv_f)
    );

    // grant: ptr breaks ties, a lone requester always wins
    assign gnt_any = req0_valid | req1_valid;
    assign gnt_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    // next-state, datapath loads and requester readies
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        opnd_d     = opnd_q;
        id_d       = id_q;
        ov_d       = ov_q;
        os_d       = os_q;
        oe_d       = oe_q;
        of_d       = of_q;
        oid_d      = oid_q;
        sat_d      = sat_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // readies stay low while reset is asserted
                if (gnt_any && !rst) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    opnd_d     = gnt_id ? req1_data : req0_data;
                    id_d       = gnt_id;
                    ptr_d      = ~gnt_id;
                    state_d    = CONV;
                end
            end
            CONV: begin
                os_d    = cv_s;
                oe_d    = cv_e;
                of_d    = cv_f;
                oid_d   = id_q;
                ov_d    = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (ov_q && out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                    if (oe_q == 3'd7 && of_q == 5'd31 &&
                        sat_q != {SAT_CNT_W{1'b1}}) begin
                        sat_d = sat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset overrides any in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            opnd_q  <= 13'd0;
            id_q    <= 1'b0;
            ov_q    <= 1'b0;
            os_q    <= 1'b0;
            oe_q    <= 3'd0;
            of_q    <= 5'd0;
            oid_q   <= 1'b0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            opnd_q  <= opnd_d;
            id_q    <= id_d;
            ov_q    <= ov_d;
            os_q    <= os_d;
            oe_q    <= oe_d;
            of_q    <= of_d;
            oid_q   <= oid_d;
            sat_q   <= sat_d;
        end
    end

    assign out_valid = ov_q;
    assign out_s     = os_q;
    assign out_e     = oe_q;
    assign out_f     = of_q;
    assign out_id    = oid_q;
    assign sat_count = sat_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_fpcvt_sched.sv
// Bench for fpcvt_sched: conversion table, directed arbitration /
// backpressure / saturation / reset sequences, then a randomized run
// scored against a transaction-level model.
module tb_fpcvt_sched;
    localparam int SW     = 4;
    localparam int SATMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [12:0]   req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          out_valid, out_ready;
    logic          out_s, out_id, busy;
    logic [2:0]    out_e;
    logic [4:0]    out_f;
    logic [SW-1:0] sat_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fpcvt_sched #(.SAT_CNT_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_e      (out_e),
        .out_f      (out_f),
        .out_id     (out_id),
        .sat_count  (sat_count),
        .busy       (busy)
    );

    typedef struct {
        logic [12:0] d;
        int          s;
        int          e;
        int          f;
    } vec_t;

    typedef struct {
        int s;
        int e;
        int f;
        int id;
    } res_t;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // reference conversion from the value itself: smallest exponent that
    // makes the magnitude fit in 5 bits, round on the next bit, clamp
    function automatic void ref_cvt(input logic [12:0] d, output int s,
                                    output int e, output int f);
        int v;
        int mag;
        v   = $signed(d);
        s   = (v < 0) ? 1 : 0;
        mag = (v < 0) ? -v : v;
        e   = 0;
        while ((mag >> e) >= 32) e++;
        f = mag >> e;
        if (e > 0) f += (mag >> (e - 1)) & 1;
        if (f == 32) begin
            f = 16;
            e++;
        end
        if (e > 7) begin
            e = 7;
            f = 31;
        end
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat", sat_count, 0);
        chk("rst_out_sef", {out_s, out_e, out_f, out_id}, 0);
    endtask

    // one request with out_ready high; checks the CONV/HOLD latency
    task automatic xfer(input int who, input logic [12:0] d, output res_t r);
        bit ok = 0;
        r = '{-1, -1, -1, -1};
        @(negedge clk);
        out_ready = 1'b1;
        if (who == 0) begin req0_valid = 1'b1; req0_data = d; end
        else          begin req1_valid = 1'b1; req1_data = d; end
        for (int c = 0; c < 20; c++) begin
            #1;
            if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("xfer_grant_timeout", 0, 1);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("lat_conv_ov", out_valid, 0);
        chk("lat_conv_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("lat_hold_ov", out_valid, 1);
        r = '{out_s, out_e, out_f, out_id};
        @(posedge clk);
    endtask

    vec_t tbl[13];
    res_t r;
    int   sat_exp;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{13'b0000001101100, 0, 2, 27};
        tbl[1]  = '{13'h0000,          0, 0, 0};
        tbl[2]  = '{13'd31,            0, 0, 31};
        tbl[3]  = '{13'd32,            0, 1, 16};
        tbl[4]  = '{13'd63,            0, 2, 16};
        tbl[5]  = '{13'h1FFF,          1, 0, 1};
        tbl[6]  = '{13'h0FFF,          0, 7, 31};
        tbl[7]  = '{13'h1000,          1, 7, 31};
        tbl[8]  = '{13'b0111111101010, 0, 7, 31};
        tbl[9]  = '{13'b0000011111101, 0, 4, 16};
        tbl[10] = '{13'b1111001011010, 1, 4, 26};
        tbl[11] = '{13'h0F80,          0, 7, 31};
        tbl[12] = '{13'd2047,          0, 7, 16};

        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; out_ready = 1'b0;
        reset_dut();

        // conversion table through requester 0
        sat_exp = 0;
        foreach (tbl[i]) begin
            xfer(0, tbl[i].d, r);
            chk($sformatf("tbl%0d_s", i), r.s, tbl[i].s);
            chk($sformatf("tbl%0d_e", i), r.e, tbl[i].e);
            chk($sformatf("tbl%0d_f", i), r.f, tbl[i].f);
            chk($sformatf("tbl%0d_id", i), r.id, 0);
            if (tbl[i].e == 7 && tbl[i].f == 31) sat_exp++;
        end
        @(negedge clk); #1;
        chk("tbl_sat_count", sat_count, sat_exp);

        // backpressure: hold 5 cycles, then deliver; req1 waits meanwhile
        @(negedge clk);
        out_ready = 1'b0; req0_valid = 1'b1; req0_data = 13'd108;
        #1;
        chk("bp_grant0", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 13'b1111001011010;
        #1;
        chk("bp_conv_r1", req1_ready, 0);
        @(negedge clk); #1;
        chk("bp_hold_ov", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_stable_ov", out_valid, 1);
            chk("bp_stable_res", {out_s, out_e, out_f, out_id}, {1'b0, 3'd2, 5'd27, 1'b0});
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("bp_after_ov", out_valid, 0);
        chk("bp_after_busy", busy, 0);
        chk("bp_next_grant1", req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("bp_r1_ov", out_valid, 1);
        chk("bp_r1_res", {out_s, out_e, out_f, out_id}, {1'b1, 3'd4, 5'd26, 1'b1});
        @(posedge clk);

        // arbitration: both held valid, deliveries alternate from 0
        reset_dut();
        begin
            int n = 0;
            @(negedge clk);
            req0_valid = 1'b1; req0_data = 13'd108;
            req1_valid = 1'b1; req1_data = 13'b1111001011010;
            out_ready = 1'b1;
            for (int c = 0; c < 40 && n < 4; c++) begin
                #1;
                chk("arb_one_ready", int'(req0_ready) + int'(req1_ready) <= 1, 1);
                if (out_valid) begin
                    chk($sformatf("arb%0d_id", n), out_id, n % 2);
                    if (n % 2 == 0)
                        chk("arb_res0", {out_s, out_e, out_f}, {1'b0, 3'd2, 5'd27});
                    else
                        chk("arb_res1", {out_s, out_e, out_f}, {1'b1, 3'd4, 5'd26});
                    n++;
                end
                @(negedge clk);
            end
            chk("arb_deliveries", n, 4);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end

        // saturation sequence
        reset_dut();
        xfer(0, 13'b1000000000000, r);
        chk("sat1", {r.s, r.e, r.f}, {1, 7, 31});
        xfer(0, 13'b0111111101010, r);
        chk("sat2", {r.s, r.e, r.f}, {0, 7, 31});
        xfer(0, 13'b0000011111101, r);
        chk("sat3", {r.s, r.e, r.f}, {0, 4, 16});
        @(negedge clk); #1;
        chk("sat_count_2", sat_count, 2);

        // reset during CONV
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 13'h0FFF; out_ready = 1'b0;
        #1;
        chk("mr_grant_a", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_conv_ov", out_valid, 0);
        chk("mr_conv_busy", busy, 0);
        chk("mr_conv_sat", sat_count, 0);
        // reset during HOLD with out_ready high: result dropped, not counted
        req0_valid = 1'b1; req0_data = 13'h0FFF;
        #1;
        chk("mr_grant_b", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk); #1;
        chk("mr_hold_ov", out_valid, 1);
        out_ready = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        #1;
        chk("mr_hold_ov0", out_valid, 0);
        chk("mr_hold_busy", busy, 0);
        chk("mr_hold_sat", sat_count, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mr_ptr_r0", req0_ready, 1);
        chk("mr_ptr_r1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // randomized run against transaction-level model
        reset_dut();
        begin
            int   mptr = 0, pending = 0, age = 0, sat_m = 0, g;
            res_t exp_r;
            bit   v0, v1;
            for (int cyc = 0; cyc < 2500; cyc++) begin
                @(negedge clk);
                v0 = 1'($urandom_range(0, 1));
                v1 = 1'($urandom_range(0, 1));
                req0_valid = v0;
                req1_valid = v1;
                req0_data = ($urandom_range(0, 5) == 0) ? 13'h1000 : 13'($urandom);
                req1_data = ($urandom_range(0, 5) == 0) ? 13'h0FF0 : 13'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                chk("rnd_sat", sat_count, sat_m);
                if (req0_ready && req1_ready) chk("rnd_two_ready", 1, 0);
                if (pending) begin
                    if (req0_ready || req1_ready) chk("rnd_ready_busy", 1, 0);
                    if (!busy) chk("rnd_busy", busy, 1);
                    if (out_valid != (age >= 2)) chk("rnd_latency_ov", out_valid, age >= 2);
                    if (out_valid && out_ready) begin
                        chk("rnd_res", {out_s, out_e, out_f, out_id},
                            {1'(exp_r.s), 3'(exp_r.e), 5'(exp_r.f), 1'(exp_r.id)});
                        if (exp_r.e == 7 && exp_r.f == 31 && sat_m < SATMAX) sat_m++;
                        pending = 0;
                    end
                end else begin
                    if (busy || out_valid) chk("rnd_idle", {busy, out_valid}, 0);
                    if (v0 || v1) begin
                        g = (v0 && v1) ? mptr : (v1 ? 1 : 0);
                        chk("rnd_grant", {req1_ready, req0_ready}, (g == 1) ? 2 : 1);
                        ref_cvt(g ? req1_data : req0_data, exp_r.s, exp_r.e, exp_r.f);
                        exp_r.id = g;
                        mptr = 1 - g;
                        pending = 1;
                        age = 0;
                    end else if (req0_ready || req1_ready) begin
                        chk("rnd_spurious_ready", 1, 0);
                    end
                end
                if (pending) age++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
